// File: rtl/cas_player.sv
// cas_player: replays a cassette image held in SDRAM as an FSK square wave.
// A fetch FSM reads image bytes into a small prefetch FIFO. A serializer
// turns each byte, LSB first, into one full square-wave cycle per bit.
// Optional build macro CAS_MOTOR_GATE_EN: when defined, the serializer only
// advances while the motor relay input en is high.
`default_nettype none

module cas_player #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HALF_1     = 12,
  parameter int unsigned HALF_0     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic              en,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic              sdram_ack,
  input  logic [7:0]        sdram_data,
  output logic              data,
  output logic              playing,
  output logic              eot
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(HALF_0);
  localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(HALF_1 - 1);
  localparam logic [CNT_W-1:0] LAST_0 = CNT_W'(HALF_0 - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  fetch_state_t      fstate, fstate_nx;
  logic              fetch_start;
  logic [ADDR_W-1:0] fptr;
  logic [ADDR_W-1:0] len_q, len_nx;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx, rd_idx;
  logic              fifo_empty, fifo_full;
  logic              push, pop;

  logic              playing_nx, eot_nx, eot_hit;
  logic              gate, run;

  logic [7:0]        sh, sh_nx, cur_sh;
  logic [3:0]        bits, bits_nx, cur_bits;
  logic              half, half_nx, cur_half;
  logic [CNT_W-1:0]  cnt, cnt_nx, cur_cnt, cur_last;
  logic              data_nx;

  // FIFO status; the extra pointer bit separates full from empty
  assign fifo_empty = (wr_idx == rd_idx);
  assign fifo_full  = (wr_idx[IDX_W] != rd_idx[IDX_W]) &&
                      (wr_idx[IDX_W-1:0] == rd_idx[IDX_W-1:0]);

  // A returning byte is kept only for a live read that is not being rewound
  assign push = (fstate == REQ) && sdram_ack && !rewind;

`ifdef CAS_MOTOR_GATE_EN
  assign gate = en;
`else
  logic unused_en;
  assign unused_en = en;
  assign gate      = 1'b1;
`endif

  // Serializer advances only while playback stays on through this edge
  assign run = playing_nx && gate;

  // Tape finished: nothing left to fetch, buffer or shift out
  assign eot_hit = playing && (bits == 4'd0) && fifo_empty &&
                   (fptr == len_q) && (fstate == IDLE);

  // Fetch FSM next state; a single read is outstanding at most
  always_comb begin
    fstate_nx   = fstate;
    fetch_start = 1'b0;
    case (fstate)
      IDLE: begin
        if (!rewind && playing && !fifo_full && (fptr < len_q)) begin
          fstate_nx   = REQ;
          fetch_start = 1'b1;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          fstate_nx = IDLE;
        end else if (rewind) begin
          fstate_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (sdram_ack) begin
          fstate_nx = IDLE;
        end
      end
      default: fstate_nx = IDLE;
    endcase
  end

  // Fetch state, request outputs and fetch pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate     <= IDLE;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
      fptr       <= '0;
    end else begin
      fstate   <= fstate_nx;
      sdram_rd <= (fstate_nx != IDLE);
      if (fetch_start) begin
        sdram_addr <= fptr;
      end
      if (rewind) begin
        fptr <= '0;
      end else if (push) begin
        fptr <= fptr + ADDR_W'(1);
      end
    end
  end

  // FIFO pointers; rewind flushes the buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (rewind) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + PTR_W'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx[IDX_W-1:0]] <= sdram_data;
    end
  end

  // Play/pause/rewind/end-of-tape control; rewind has priority over play
  always_comb begin
    playing_nx = playing;
    eot_nx     = eot;
    len_nx     = len_q;
    if (rewind) begin
      playing_nx = 1'b0;
      eot_nx     = 1'b0;
      len_nx     = tape_len;
    end else if (play) begin
      if (playing) begin
        playing_nx = 1'b0;
      end else if (!eot) begin
        len_nx = tape_len;
        if (tape_len == '0) begin
          eot_nx = 1'b1;
        end else begin
          playing_nx = 1'b1;
        end
      end
    end else if (eot_hit) begin
      playing_nx = 1'b0;
      eot_nx     = 1'b1;
    end
  end

  // Serializer: emit one waveform sample per running cycle, loading a new
  // byte from the FIFO without a gap when the shift register runs dry
  always_comb begin
    sh_nx    = sh;
    bits_nx  = bits;
    half_nx  = half;
    cnt_nx   = cnt;
    data_nx  = 1'b0;
    pop      = 1'b0;
    cur_sh   = sh;
    cur_bits = bits;
    cur_half = half;
    cur_cnt  = cnt;
    cur_last = '0;
    if (rewind) begin
      sh_nx   = '0;
      bits_nx = '0;
      half_nx = 1'b0;
      cnt_nx  = '0;
    end else if (run) begin
      if ((bits == 4'd0) && !fifo_empty) begin
        pop      = 1'b1;
        cur_sh   = mem[rd_idx[IDX_W-1:0]];
        cur_bits = 4'd8;
        cur_half = 1'b0;
        cur_cnt  = '0;
      end
      if (cur_bits != 4'd0) begin
        data_nx  = !cur_half;
        cur_last = cur_sh[0] ? LAST_1 : LAST_0;
        if (cur_cnt == cur_last) begin
          cnt_nx = '0;
          if (!cur_half) begin
            half_nx = 1'b1;
            sh_nx   = cur_sh;
            bits_nx = cur_bits;
          end else begin
            half_nx = 1'b0;
            sh_nx   = {1'b0, cur_sh[7:1]};
            bits_nx = cur_bits - 4'd1;
          end
        end else begin
          cnt_nx  = cur_cnt + CNT_W'(1);
          half_nx = cur_half;
          sh_nx   = cur_sh;
          bits_nx = cur_bits;
        end
      end
    end
  end

  // Control and serializer registers, waveform output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      playing <= 1'b0;
      eot     <= 1'b0;
      len_q   <= '0;
      sh      <= '0;
      bits    <= '0;
      half    <= 1'b0;
      cnt     <= '0;
      data    <= 1'b0;
    end else begin
      playing <= playing_nx;
      eot     <= eot_nx;
      len_q   <= len_nx;
      sh      <= sh_nx;
      bits    <= bits_nx;
      half    <= half_nx;
      cnt     <= cnt_nx;
      data    <= data_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cas_player.sv
// Bench for cas_player: table vectors, random images against a waveform
// model built from byte values, and hand sequences for rewind, pause,
// motor gating (CAS_MOTOR_GATE_EN) and asynchronous reset.
`timescale 1ns/1ps

module tb_cas_player;

  logic        clk;
  logic        reset;
  logic        play, rewind, en;
  logic [15:0] tape_len;
  logic [15:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack;
  logic [7:0]  sdram_data;
  logic        data, playing, eot;

  cas_player #(.ADDR_W(16), .FIFO_DEPTH(4), .HALF_1(4), .HALF_0(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .rewind     (rewind),
    .en         (en),
    .tape_len   (tape_len),
    .sdram_addr (sdram_addr),
    .sdram_rd   (sdram_rd),
    .sdram_ack  (sdram_ack),
    .sdram_data (sdram_data),
    .data       (data),
    .playing    (playing),
    .eot        (eot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total_n = 0;
  int bad_n   = 0;

  logic [7:0] img [256];
  int  exp_h[$];
  int  addr_log[$];
  int  ack_count  = 0;
  int  ack_delay  = 1;
  bit  rand_delay = 0;
  int  wait_cnt   = 0;
  int  cur_delay  = 0;

  typedef struct {
    int         len;
    logic [7:0] b0;
    logic [7:0] b1;
    int         dly;
    int         exp_tot;
    int         exp_hi;
  } vec_t;
  vec_t vecs[5];

  int tot, nh, hi, br;

  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Half-wave length per bit of the loaded image, LSB first
  function automatic void build_model(input int len);
    exp_h.delete();
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++)
        exp_h.push_back(img[i][b] ? 4 : 8);
  endfunction

  // SDRAM responder: acks a held read after a delay, returns image bytes
  initial begin
    sdram_ack  = 1'b0;
    sdram_data = 8'h00;
    forever begin
      @(negedge clk);
      sdram_ack = 1'b0;
      if (!sdram_rd) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0)
          cur_delay = rand_delay ? int'($urandom_range(0, 4)) : ack_delay;
        if (wait_cnt >= cur_delay) begin
          sdram_ack  = 1'b1;
          sdram_data = img[sdram_addr[7:0]];
          addr_log.push_back(int'(sdram_addr));
          ack_count++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic pulse_play;
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
  endtask

  task automatic pulse_rewind;
    @(negedge clk); rewind = 1'b1;
    @(negedge clk); rewind = 1'b0;
  endtask

  task automatic wait_rd_idle;
    for (int k = 0; k < 40 && sdram_rd; k++) @(negedge clk);
  endtask

  task automatic wait_rise(input string nm, input int max_cyc);
    for (int k = 0; k < max_cyc && data !== 1'b1; k++) @(negedge clk);
    chk(nm, int'(data === 1'b1), 1);
  endtask

  // Record the waveform until eot: cycles from first rise to eot, high
  // samples, high runs, and runs that differ from the model
  task automatic measure(input int max_cyc, output int t_tot, output int n_hi_runs,
                         output int n_hi, output int n_bad);
    int first, run, level;
    bit d;
    t_tot = -1; n_hi_runs = 0; n_hi = 0; n_bad = 0;
    first = -1; run = 0; level = 0;
    for (int t = 1; t <= max_cyc; t++) begin
      @(negedge clk);
      if (eot) begin
        if (first >= 0) t_tot = t - first;
        if (level == 0 && n_hi_runs > 0 && run != exp_h[n_hi_runs-1]) n_bad++;
        break;
      end
      d = data;
      if (d) n_hi++;
      if (first < 0) begin
        if (d) begin first = t; level = 1; run = 1; end
      end else if (int'(d) == level) begin
        run++;
      end else begin
        if (level == 1) begin
          if (n_hi_runs >= exp_h.size() || run != exp_h[n_hi_runs]) n_bad++;
          n_hi_runs++;
        end else if (run != exp_h[n_hi_runs-1]) begin
          n_bad++;
        end
        level = int'(d);
        run   = 1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1, 8'h01, 8'h00, 1, 120, 60};
    vecs[1] = '{1, 8'hFF, 8'h00, 0,  64, 32};
    vecs[2] = '{1, 8'h00, 8'h00, 2, 128, 64};
    vecs[3] = '{2, 8'h0F, 8'hF0, 1, 192, 96};
    vecs[4] = '{2, 8'h03, 8'h00, 3, 240, 120};
    for (int i = 0; i < 256; i++) img[i] = 8'h00;

    reset = 1'b0; play = 1'b0; rewind = 1'b0; en = 1'b1; tape_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_rd", sdram_rd, 0);
    chk("rst_playing", playing, 0);
    chk("rst_eot", eot, 0);
    chk("rst_addr", sdram_addr, 0);
    @(negedge clk); reset = 1'b1;

    // Empty tape: first play reports end of tape, later plays ignored
    tape_len = 16'd0;
    pulse_rewind; pulse_play;
    chk("len0_eot", eot, 1);
    chk("len0_playing", playing, 0);
    pulse_play;
    chk("len0_replay_playing", playing, 0);
    chk("len0_replay_eot", eot, 1);

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      img[0] = vecs[v].b0; img[1] = vecs[v].b1;
      ack_delay = vecs[v].dly;
      build_model(vecs[v].len);
      tape_len = 16'(vecs[v].len);
      pulse_rewind; pulse_play;
      measure(vecs[v].len * 128 + 200, tot, nh, hi, br);
      chk($sformatf("vec%0d_total", v), tot, vecs[v].exp_tot);
      chk($sformatf("vec%0d_highs", v), hi, vecs[v].exp_hi);
      chk($sformatf("vec%0d_bits", v), nh, 8 * vecs[v].len);
      chk($sformatf("vec%0d_runs", v), br, 0);
    end
    chk("eot_end_playing", playing, 0);
    pulse_play;
    chk("eot_play_ignored", playing, 0);
    chk("eot_held", eot, 1);

    // Random images with random ack latency
    rand_delay = 1'b1;
    for (int it = 0; it < 6; it++) begin
      int len, sum;
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) img[i] = 8'($urandom);
      build_model(len);
      sum = 0;
      foreach (exp_h[k]) sum += 2 * exp_h[k];
      tape_len = 16'(len);
      pulse_rewind; pulse_play;
      measure(len * 128 + 300, tot, nh, hi, br);
      chk($sformatf("rnd%0d_total", it), tot, sum);
      chk($sformatf("rnd%0d_bits", it), nh, 8 * len);
      chk($sformatf("rnd%0d_runs", it), br, 0);
    end
    rand_delay = 1'b0;

    // Prefetch depth: one byte shifting plus a full FIFO, then no reads
    for (int i = 0; i < 8; i++) img[i] = 8'hC3 ^ 8'(i);
    tape_len = 16'd8; ack_delay = 3;
    pulse_rewind; wait_rd_idle;
    ack_count = 0; addr_log.delete();
    pulse_play;
    wait_rise("buf_rise", 100);
    repeat (40) @(negedge clk);
    #1;
    chk("buf_acks", ack_count, 5);
    chk("buf_rd_held_off", sdram_rd, 0);
    if (addr_log.size() == 5) chk("buf_last_addr", addr_log[4], 4);
    pulse_rewind; wait_rd_idle;

    // Rewind with a read in flight: late data dropped, restart at 0
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03;
    tape_len = 16'd3; ack_delay = 6;
    pulse_rewind;
    ack_count = 0; addr_log.delete();
    pulse_play;
    for (int k = 0; k < 100 && !(ack_count >= 1 && sdram_rd); k++) begin
      @(negedge clk); #1;
    end
    chk("disc_second_read", int'(ack_count >= 1 && sdram_rd), 1);
    rewind = 1'b1;
    @(negedge clk); rewind = 1'b0;
    chk("disc_playing", playing, 0);
    for (int k = 0; k < 20 && sdram_rd; k++) @(negedge clk);
    chk("disc_rd_released", sdram_rd, 0);
    chk("disc_data", data, 0);
    ack_delay = 1; addr_log.delete();
    build_model(3);
    pulse_play;
    measure(600, tot, nh, hi, br);
    chk("disc_fetches", addr_log.size(), 3);
    if (addr_log.size() > 0) chk("disc_first_addr", addr_log[0], 0);
    chk("disc_total", tot, 352);
    chk("disc_runs", br, 0);

    // Play and rewind together while playing
    img[0] = 8'h00; img[1] = 8'h00;
    tape_len = 16'd2;
    pulse_rewind; pulse_play;
    wait_rise("pr_rise", 100);
    repeat (3) @(negedge clk);
    play = 1'b1; rewind = 1'b1;
    @(negedge clk); play = 1'b0; rewind = 1'b0;
    chk("pr_playing", playing, 0);
    chk("pr_eot", eot, 0);
    chk("pr_data", data, 0);
    wait_rd_idle;

    // Pause mid half-wave, resume from the frozen point
    img[0] = 8'h00; tape_len = 16'd1;
    build_model(1);
    pulse_rewind; pulse_play;
    fork
      measure(400, tot, nh, hi, br);
      begin
        wait_rise("pause_rise", 100);
        repeat (3) @(negedge clk);
        pulse_play;
        repeat (5) @(negedge clk);
        pulse_play;
      end
    join
    chk("pause_total", tot, 135);
    chk("pause_highs", hi, 64);

`ifdef CAS_MOTOR_GATE_EN
    // Motor off mid half-wave stretches the waveform by the off time
    pulse_rewind; pulse_play;
    fork
      measure(400, tot, nh, hi, br);
      begin
        wait_rise("gate_rise", 100);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
    join
    chk("gate_total", tot, 138);
    chk("gate_highs", hi, 64);
    chk("gate_playing", playing, 0);
`else
    // Motor relay has no effect in the default build
    img[0] = 8'h01;
    build_model(1);
    pulse_rewind; pulse_play;
    fork
      measure(400, tot, nh, hi, br);
      begin
        repeat (150) begin
          @(negedge clk);
          en = 1'($urandom_range(0, 1));
        end
        en = 1'b1;
      end
    join
    chk("en_total", tot, 120);
    chk("en_highs", hi, 60);
    chk("en_runs", br, 0);
`endif

    // Asynchronous reset mid-bit, then a fresh play from address 0
    img[0] = 8'h01; tape_len = 16'd1; ack_delay = 1;
    pulse_rewind; pulse_play;
    wait_rise("arst_rise", 100);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_data", data, 0);
    chk("arst_rd", sdram_rd, 0);
    chk("arst_playing", playing, 0);
    chk("arst_eot", eot, 0);
    chk("arst_addr", sdram_addr, 0);
    @(negedge clk); reset = 1'b1;
    addr_log.delete();
    build_model(1);
    pulse_play;
    measure(400, tot, nh, hi, br);
    chk("arst_fetches", addr_log.size(), 1);
    if (addr_log.size() > 0) chk("arst_first_addr", addr_log[0], 0);
    chk("arst_total", tot, 120);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
